score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 145 ++++++++++++++
 tb/tb_score_keeper.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: game-state sequencer for a rhythm game.
// Counts hits and misses during PLAY, handles pause/resume, and ends the game
// as a win (score reaches WIN_SCORE) or a loss (miss count reaches MAX_MISS).
// Every output comes straight from a register.
module score_keeper #(
  parameter int unsigned READY_CYCLES = 4,
  parameter int unsigned MAX_MISS     = 9,
  parameter int unsigned WIN_SCORE    = 15
) (
  input  logic       mid_clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       hit_evt,
  input  logic       miss_evt,
  output logic [2:0] state,
  output logic [3:0] score,
  output logic [3:0] miss,
  output logic       win
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    READY = 3'b001,
    PLAY  = 3'b010,
    PAUSE = 3'b011,
    OVER  = 3'b100
  } state_t;

  localparam logic [3:0] READY_LOAD = 4'(READY_CYCLES - 1);
  localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISS);
  localparam logic [3:0] WIN_LIMIT  = 4'(WIN_SCORE);

  state_t     state_q, state_n;
  logic [3:0] score_q, score_n;
  logic [3:0] miss_q, miss_n;
  logic       win_q, win_n;
  logic [3:0] rcnt_q, rcnt_n;
  logic       start_q, pause_q;
  logic       start_stb, pause_stb;
  logic [3:0] score_inc, miss_inc;
  logic       any_evt;

  // Increment that sticks at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Edge-detect registers; cleared by reset so a level held across reset
  // release counts as one rising edge.
  always_ff @(posedge mid_clk or negedge rst) begin
    if (!rst) begin
      start_q <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      start_q <= start;
      pause_q <= pause;
    end
  end

  assign start_stb = start & ~start_q;
  assign pause_stb = pause & ~pause_q;
  assign score_inc = sat_inc(score_q);
  assign miss_inc  = sat_inc(miss_q);
  assign any_evt   = hit_evt | miss_evt;

  // State, counter and result registers.
  always_ff @(posedge mid_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      score_q <= '0;
      miss_q  <= '0;
      win_q   <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_n;
      score_q <= score_n;
      miss_q  <= miss_n;
      win_q   <= win_n;
      rcnt_q  <= rcnt_n;
    end
  end

  // Next-state and next-counter logic.
  always_comb begin
    state_n = state_q;
    score_n = score_q;
    miss_n  = miss_q;
    win_n   = win_q;
    rcnt_n  = rcnt_q;
    case (state_q)
      IDLE: begin
        if (start_stb) begin
          state_n = READY;
          score_n = '0;
          miss_n  = '0;
          win_n   = 1'b0;
          rcnt_n  = READY_LOAD;
        end
      end
      READY: begin
        if (rcnt_q == 4'd0) state_n = PLAY;
        else                rcnt_n  = rcnt_q - 4'd1;
      end
      PLAY: begin
        // A pause edge coinciding with a hit/miss is dropped so the event is
        // never lost; the player must press pause again.
        if (pause_stb && !any_evt) begin
          state_n = PAUSE;
        end else begin
          if (hit_evt)  score_n = score_inc;
          if (miss_evt) miss_n  = miss_inc;
          // Loss is checked first so it wins when both limits hit together.
          if (miss_evt && miss_inc == MISS_LIMIT) begin
            state_n = OVER;
            win_n   = 1'b0;
          end else if (hit_evt && score_inc == WIN_LIMIT) begin
            state_n = OVER;
            win_n   = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (start_stb)      state_n = IDLE;
        else if (pause_stb) state_n = PLAY;
      end
      OVER: begin
        if (start_stb) begin
          state_n = READY;
          score_n = '0;
          miss_n  = '0;
          win_n   = 1'b0;
          rcnt_n  = READY_LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign state = state_q;
  assign score = score_q;
  assign miss  = miss_q;
  assign win   = win_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed testbench for score_keeper with hand-computed expectations.
module tb_score_keeper;

  logic       mid_clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic       hit_evt;
  logic       miss_evt;
  logic [2:0] state;
  logic [3:0] score;
  logic [3:0] miss;
  logic       win;

  int unsigned n_cmp;
  int unsigned n_err;

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_READY = 3'b001;
  localparam logic [2:0] S_PLAY  = 3'b010;
  localparam logic [2:0] S_PAUSE = 3'b011;
  localparam logic [2:0] S_OVER  = 3'b100;

  score_keeper #(
    .READY_CYCLES(4),
    .MAX_MISS(9),
    .WIN_SCORE(15)
  ) dut (
    .mid_clk(mid_clk),
    .rst(rst),
    .start(start),
    .pause(pause),
    .hit_evt(hit_evt),
    .miss_evt(miss_evt),
    .state(state),
    .score(score),
    .miss(miss),
    .win(win)
  );

  initial mid_clk = 1'b0;
  always #5 mid_clk = ~mid_clk;

  task automatic tick();
    @(posedge mid_clk);
    #1;
  endtask

  task automatic pulse_hit(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      hit_evt = 1'b1; tick(); hit_evt = 1'b0; tick();
    end
  endtask

  task automatic pulse_miss(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      miss_evt = 1'b1; tick(); miss_evt = 1'b0; tick();
    end
  endtask

  // Start a new game and step through the four READY cycles into PLAY.
  task automatic new_game();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; pause = 1'b0; hit_evt = 1'b0; miss_evt = 1'b0;
    #2;
    n_cmp++;
    if ({state, score, miss, win} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got state=%b score=%0d miss=%0d win=%b, want all 0", state, score, miss, win);
    end
    #20 rst = 1'b1;
    tick();
    n_cmp++;
    if (state !== S_IDLE) begin
      n_err++; $display("FAIL idle_after_reset: got %b want %b", state, S_IDLE);
    end
  endtask

  task automatic test_ready_window();
    int unsigned ready_seen;
    ready_seen = 0;
    start = 1'b1; tick();
    for (int unsigned i = 0; i < 4; i++) begin
      if (state == S_READY) ready_seen++;
      if (i == 0) start = 1'b0;
      tick();
    end
    n_cmp++;
    if (ready_seen != 4) begin
      n_err++; $display("FAIL ready_length: got %0d cycles want 4", ready_seen);
    end
    n_cmp++;
    if ({state, score, miss} !== {S_PLAY, 4'd0, 4'd0}) begin
      n_err++; $display("FAIL enter_play: got state=%b score=%0d miss=%0d want 010/0/0", state, score, miss);
    end
  endtask

  task automatic test_counts();
    pulse_hit(1); pulse_miss(1); pulse_hit(1);
    // start edge during PLAY must be ignored
    start = 1'b1; tick(); start = 1'b0;
    pulse_miss(1); pulse_hit(1);
    n_cmp++;
    if ({state, score, miss} !== {S_PLAY, 4'd3, 4'd2}) begin
      n_err++; $display("FAIL counts: got state=%b score=%0d miss=%0d want 010/3/2", state, score, miss);
    end
  endtask

  task automatic test_pause();
    pause = 1'b1; tick();
    n_cmp++;
    if (state !== S_PAUSE) begin
      n_err++; $display("FAIL pause_enter: got %b want %b", state, S_PAUSE);
    end
    pulse_hit(2); pulse_miss(1);
    pause = 1'b0; tick(); pause = 1'b1; tick();
    n_cmp++;
    if ({state, score, miss} !== {S_PLAY, 4'd3, 4'd2}) begin
      n_err++; $display("FAIL pause_resume: got state=%b score=%0d miss=%0d want 010/3/2", state, score, miss);
    end
    // pause edge together with a hit: hit applies, pause dropped
    pause = 1'b0; tick();
    pause = 1'b1; hit_evt = 1'b1; tick(); hit_evt = 1'b0;
    n_cmp++;
    if ({state, score} !== {S_PLAY, 4'd4}) begin
      n_err++; $display("FAIL pause_with_event: got state=%b score=%0d want 010/4", state, score);
    end
    pause = 1'b0; tick();
  endtask

  task automatic test_loss();
    pulse_miss(6);
    n_cmp++;
    if ({state, score, miss} !== {S_PLAY, 4'd4, 4'd8}) begin
      n_err++; $display("FAIL pre_loss: got state=%b score=%0d miss=%0d want 010/4/8", state, score, miss);
    end
    hit_evt = 1'b1; miss_evt = 1'b1; tick(); hit_evt = 1'b0; miss_evt = 1'b0;
    n_cmp++;
    if ({state, score, miss, win} !== {S_OVER, 4'd5, 4'd9, 1'b0}) begin
      n_err++; $display("FAIL loss: got state=%b score=%0d miss=%0d win=%b want 100/5/9/0", state, score, miss, win);
    end
    tick(); pulse_hit(1);
    n_cmp++;
    if ({state, score, miss} !== {S_OVER, 4'd5, 4'd9}) begin
      n_err++; $display("FAIL over_hold: got state=%b score=%0d miss=%0d want 100/5/9", state, score, miss);
    end
  endtask

  task automatic test_win();
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++;
    if ({state, score, miss, win} !== {S_READY, 4'd0, 4'd0, 1'b0}) begin
      n_err++; $display("FAIL restart_clear: got state=%b score=%0d miss=%0d win=%b want 001/0/0/0", state, score, miss, win);
    end
    tick(); tick(); tick(); tick();
    pulse_hit(14);
    n_cmp++;
    if ({state, score} !== {S_PLAY, 4'd14}) begin
      n_err++; $display("FAIL pre_win: got state=%b score=%0d want 010/14", state, score);
    end
    pulse_hit(1);
    n_cmp++;
    if ({state, score, win} !== {S_OVER, 4'd15, 1'b1}) begin
      n_err++; $display("FAIL win: got state=%b score=%0d win=%b want 100/15/1", state, score, win);
    end
    pulse_hit(2);
    n_cmp++;
    if ({score, win} !== {4'd15, 1'b1}) begin
      n_err++; $display("FAIL win_saturate: got score=%0d win=%b want 15/1", score, win);
    end
  endtask

  task automatic test_loss_priority();
    new_game();
    pulse_hit(14); pulse_miss(8);
    hit_evt = 1'b1; miss_evt = 1'b1; tick(); hit_evt = 1'b0; miss_evt = 1'b0;
    n_cmp++;
    if ({state, score, miss, win} !== {S_OVER, 4'd15, 4'd9, 1'b0}) begin
      n_err++; $display("FAIL loss_priority: got state=%b score=%0d miss=%0d win=%b want 100/15/9/0", state, score, miss, win);
    end
  endtask

  task automatic test_pause_to_idle();
    new_game();
    pulse_hit(2); pulse_miss(1);
    pause = 1'b1; tick(); pause = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++;
    if ({state, score, miss} !== {S_IDLE, 4'd2, 4'd1}) begin
      n_err++; $display("FAIL pause_to_idle: got state=%b score=%0d miss=%0d want 000/2/1", state, score, miss);
    end
    tick();
  endtask

  task automatic test_reset_midgame();
    int unsigned ready_seen;
    new_game();
    pulse_hit(5);
    start = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({state, score, miss, win} !== 12'h000) begin
      n_err++; $display("FAIL reset_midgame: got state=%b score=%0d miss=%0d win=%b want all 0", state, score, miss, win);
    end
    @(negedge mid_clk);
    rst = 1'b1;
    ready_seen = 0;
    for (int unsigned i = 0; i < 12; i++) begin
      tick();
      if (state == S_READY) ready_seen++;
    end
    n_cmp++;
    if ({ready_seen, state} !== {32'd4, S_PLAY}) begin
      n_err++; $display("FAIL held_start_once: got ready_cycles=%0d state=%b want 4/010", ready_seen, state);
    end
    start = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_ready_window();
    test_counts();
    test_pause();
    test_loss();
    test_win();
    test_loss_priority();
    test_pause_to_idle();
    test_reset_midgame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
